// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, synchronous flush and
// registered handshake pulses. Depth need not be a power of two.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] AE_THRESH = CNT_W'(AE_MARGIN);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = rd_en && (count != '0);
        wr_acc = wr_en && ((count != DEPTH_C) || rd_acc);
    end

    always_comb begin
        full        = (count == DEPTH_C);
        empty       = (count == '0);
        almostfull  = (count >= AF_THRESH) && !full;
        almostempty = (count <= AE_THRESH) && !empty;
    end

    // Storage carries no reset; flush and reset only suppress the write.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;

            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end

            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a default 8-deep instance for fill/drain,
// concurrency and flush, and a 5-deep instance checked against a queue model.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=16, DEPTH=8, margins 1
    logic        a_rst_n, a_flush, a_wr_en, a_rd_en;
    logic [15:0] a_data_in, a_data_out;
    logic        a_wr_ack, a_overflow, a_underflow;
    logic        a_full, a_empty, a_almostfull, a_almostempty;
    logic [3:0]  a_count;

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush), .data_in(a_data_in),
        .wr_en(a_wr_en), .rd_en(a_rd_en), .data_out(a_data_out),
        .wr_ack(a_wr_ack), .overflow(a_overflow), .underflow(a_underflow),
        .full(a_full), .empty(a_empty), .almostfull(a_almostfull),
        .almostempty(a_almostempty), .count(a_count)
    );

    // Instance B: WIDTH=16, DEPTH=5, margins 2
    logic        b_rst_n, b_flush, b_wr_en, b_rd_en;
    logic [15:0] b_data_in, b_data_out;
    logic        b_wr_ack, b_overflow, b_underflow;
    logic        b_full, b_empty, b_almostfull, b_almostempty;
    logic [2:0]  b_count;

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush), .data_in(b_data_in),
        .wr_en(b_wr_en), .rd_en(b_rd_en), .data_out(b_data_out),
        .wr_ack(b_wr_ack), .overflow(b_overflow), .underflow(b_underflow),
        .full(b_full), .empty(b_empty), .almostfull(b_almostfull),
        .almostempty(b_almostempty), .count(b_count)
    );

    bit wr_pat [23] = '{1,1,1,1,1,1,1,0,1,1,0,1,1,1,0,0,1,0,1,0,0,0,0};
    bit rd_pat [23] = '{0,0,0,0,0,0,1,1,1,0,1,1,1,0,1,1,1,1,0,1,1,1,1};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic fl,
                                 input logic [15:0] din);
        a_wr_en   = wr;
        a_rd_en   = rd;
        a_flush   = fl;
        a_data_in = din;
        @(posedge clk);
        #1;
    endtask

    // Status expectations for the 8-deep, margin-1 instance from expected count.
    task automatic checkStateA(input string tag, input int exp_count, input logic exp_ack,
                               input logic exp_ovf, input logic exp_udf);
        checkOutput({tag, ".count"},       32'(a_count),       32'(exp_count));
        checkOutput({tag, ".wr_ack"},      32'(a_wr_ack),      32'(exp_ack));
        checkOutput({tag, ".overflow"},    32'(a_overflow),    32'(exp_ovf));
        checkOutput({tag, ".underflow"},   32'(a_underflow),   32'(exp_udf));
        checkOutput({tag, ".full"},        32'(a_full),        32'(exp_count == 8));
        checkOutput({tag, ".empty"},       32'(a_empty),       32'(exp_count == 0));
        checkOutput({tag, ".almostfull"},  32'(a_almostfull),  32'(exp_count == 7));
        checkOutput({tag, ".almostempty"}, 32'(a_almostempty), 32'(exp_count == 1));
    endtask

    initial begin
        logic [15:0] q [$];
        logic [15:0] exp_dout;
        logic        rd_ok, wr_ok;

        a_rst_n = 1'b0; a_flush = 1'b0; a_wr_en = 1'b1; a_rd_en = 1'b1; a_data_in = 16'hDEAD;
        b_rst_n = 1'b0; b_flush = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_data_in = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        checkStateA("reset", 0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.data_out", 32'(a_data_out), 32'h0);
        a_rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
            checkStateA($sformatf("fill%0d", i), i, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0009);
        checkStateA("fill9", 8, 1'b0, 1'b1, 1'b0);

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
            checkStateA($sformatf("drain%0d", i), 8 - i, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("drain%0d.data_out", i), 32'(a_data_out), 32'(i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkStateA("drain9", 0, 1'b0, 1'b0, 1'b1);
        checkOutput("drain9.data_out", 32'(a_data_out), 32'h0008);

        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h10 + i));
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hAAAA);
        checkStateA("fullrw", 8, 1'b1, 1'b0, 1'b0);
        checkOutput("fullrw.data_out", 32'(a_data_out), 32'h0011);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput($sformatf("after_fullrw%0d", i), 32'(a_data_out), 32'(16'h10 + i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("aaaa_out", 32'(a_data_out), 32'hAAAA);
        checkStateA("aaaa_out", 0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h5555);
        checkStateA("emptyrw", 1, 1'b1, 1'b0, 1'b1);
        checkOutput("emptyrw.data_out", 32'(a_data_out), 32'hAAAA);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("emptyrw_read", 32'(a_data_out), 32'h5555);

        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h20 + i));
        checkOutput("preflush.count", 32'(a_count), 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0099);
        checkStateA("flush", 0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush.data_out", 32'(a_data_out), 32'h5555);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0077);
        checkStateA("postflush_wr", 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("postflush_rd", 32'(a_data_out), 32'h0077);
        checkStateA("postflush_rd", 0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0033);
        a_rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0044);
        a_rst_n = 1'b1;
        checkStateA("midreset", 0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset.data_out", 32'(a_data_out), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

        // Odd-depth instance: traffic pattern checked against a queue model.
        @(posedge clk);
        #1;
        b_rst_n  = 1'b1;
        exp_dout = 16'h0;
        checkOutput("b_reset.empty", 32'(b_empty), 32'h1);
        checkOutput("b_reset.count", 32'(b_count), 32'h0);
        for (int c = 0; c < 23; c++) begin
            b_wr_en   = wr_pat[c];
            b_rd_en   = rd_pat[c];
            b_data_in = 16'(16'h100 + c);
            rd_ok = b_rd_en && (q.size() != 0);
            wr_ok = b_wr_en && ((q.size() != 5) || rd_ok);
            if (rd_ok) exp_dout = q.pop_front();
            if (wr_ok) q.push_back(b_data_in);
            @(posedge clk);
            #1;
            checkOutput($sformatf("b%0d.count", c),     32'(b_count),     32'(q.size()));
            checkOutput($sformatf("b%0d.data_out", c),  32'(b_data_out),  32'(exp_dout));
            checkOutput($sformatf("b%0d.wr_ack", c),    32'(b_wr_ack),    32'(wr_ok));
            checkOutput($sformatf("b%0d.overflow", c),  32'(b_overflow),  32'(b_wr_en && !wr_ok));
            checkOutput($sformatf("b%0d.underflow", c), 32'(b_underflow), 32'(b_rd_en && !rd_ok));
            checkOutput($sformatf("b%0d.full", c),      32'(b_full),      32'(q.size() == 5));
            checkOutput($sformatf("b%0d.empty", c),     32'(b_empty),     32'(q.size() == 0));
            checkOutput($sformatf("b%0d.almostfull", c),  32'(b_almostfull),
                        32'(q.size() == 3 || q.size() == 4));
            checkOutput($sformatf("b%0d.almostempty", c), 32'(b_almostempty),
                        32'(q.size() == 1 || q.size() == 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
